// File: rtl/btop_sched_pkg.sv
// Shared definitions for the b_top partial-sum RAM sequencer: code geometry,
// beat counts, slot index type and the frame state encoding.
package btop_sched_pkg;

  localparam int N = 1024;
  localparam int P = 128;
  localparam int Q = 6;

  function automatic int calc_wbeats(input int n, input int p);
    return n / (4 * p);
  endfunction

  function automatic int calc_rbeats(input int n, input int p);
    return n / (2 * p);
  endfunction

  localparam int WBEATS   = calc_wbeats(N, P);
  localparam int RBEATS   = calc_rbeats(N, P);
  localparam int WR_BEAT_W = 2 * P * Q;
  localparam int RD_BEAT_W = P * Q;
  localparam int SB_W     = (WBEATS > 1) ? $clog2(WBEATS) : 1;

  // Slot index as seen on the RAM's cnta/cntb counters.
  typedef logic [3:0]      slot_idx_t;
  typedef logic [SB_W-1:0] sb_idx_t;

  localparam slot_idx_t WBEATS_S   = slot_idx_t'(WBEATS);
  localparam slot_idx_t RBEATS_S   = slot_idx_t'(RBEATS);
  localparam slot_idx_t LAST_RBEAT = slot_idx_t'(RBEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/btop_sched_if.sv
// Handshake bundle between the b_top sequencer and its producer/consumer/RAM.
// master drives frame start, write offers and read requests; slave is the sequencer.
interface btop_sched_if;
  import btop_sched_pkg::*;

  logic      start;
  logic      wr_valid;
  logic      wr_ready;
  logic      rd_req;
  slot_idx_t cnta;
  logic      w_en;
  slot_idx_t cntb;
  logic      r_en;
  logic      rd_valid;
  slot_idx_t rd_idx;
  logic      busy;
  logic      frame_done;

  modport master (
    output start, wr_valid, rd_req,
    input  wr_ready, cnta, w_en, cntb, r_en, rd_valid, rd_idx, busy, frame_done
  );

  modport slave (
    input  start, wr_valid, rd_req,
    output wr_ready, cnta, w_en, cntb, r_en, rd_valid, rd_idx, busy, frame_done
  );

endinterface

// File: rtl/btop_scoreboard.sv
// Per-slot written bits: cleared at frame start, set by a landed write beat,
// queried combinationally by read slot modulo WBEATS (registered state only).
module btop_scoreboard
  import btop_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr_i,
  input  logic      set_i,
  input  slot_idx_t set_idx_i,
  input  slot_idx_t query_idx_i,
  output logic      written_o
);

  logic [WBEATS-1:0] written_q;
  sb_idx_t           set_sel;
  sb_idx_t           qry_sel;

  always_comb begin
    set_sel   = sb_idx_t'(set_idx_i % WBEATS_S);
    qry_sel   = sb_idx_t'(query_idx_i % WBEATS_S);
    written_o = written_q[qry_sel];
  end

  always_ff @(posedge clk) begin
    if (!rst || clr_i) begin
      written_q <= '0;
    end else if (set_i) begin
      written_q[set_sel] <= 1'b1;
    end
  end

endmodule

// File: rtl/btop_sched.sv
// b_top RAM sequencer: same-cycle write handshake and read issue, read data 1 cycle later.
// Writes stall once all WBEATS beats landed; reads stall until their slot is written.
module btop_sched
  import btop_sched_pkg::*;
(
  input logic        clk,
  input logic        rst,
  btop_sched_if.slave sched_if
);

  state_e    state_q;
  slot_idx_t wcnt_q;
  slot_idx_t rcnt_q;
  slot_idx_t rd_idx_q;
  logic      busy_q;
  logic      rd_valid_q;
  logic      frame_done_q;

  logic      active;
  logic      wr_ready;
  logic      w_en;
  logic      r_en;
  logic      slot_written;
  logic      sb_clr;
  slot_idx_t cnta;
  slot_idx_t cntb;

  // Counters are stale in IDLE until the next start, so the RAM sees zero there.
  always_comb begin
    active   = (state_q == ST_ACTIVE);
    wr_ready = active && (wcnt_q < WBEATS_S);
    w_en     = wr_ready && sched_if.wr_valid;
    r_en     = active && sched_if.rd_req && (rcnt_q < RBEATS_S) && slot_written;
    cnta     = (state_q == ST_IDLE) ? '0 : wcnt_q;
    cntb     = (state_q == ST_IDLE) ? '0 : rcnt_q;
    sb_clr   = (state_q == ST_IDLE) && sched_if.start;
  end

  btop_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (sb_clr),
    .set_i       (w_en),
    .set_idx_i   (wcnt_q),
    .query_idx_i (rcnt_q),
    .written_o   (slot_written)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      busy_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_idx_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rd_valid_q   <= r_en;
      rd_idx_q     <= cntb;
      frame_done_q <= r_en && (cntb == LAST_RBEAT);

      case (state_q)
        ST_IDLE: begin
          if (sched_if.start) begin
            state_q <= ST_ACTIVE;
            busy_q  <= 1'b1;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_en) begin
            wcnt_q <= wcnt_q + 4'd1;
          end
          if (r_en) begin
            rcnt_q <= rcnt_q + 4'd1;
            if (rcnt_q == LAST_RBEAT) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sched_if.wr_ready   = wr_ready;
  assign sched_if.w_en       = w_en;
  assign sched_if.cnta       = cnta;
  assign sched_if.r_en       = r_en;
  assign sched_if.cntb       = cntb;
  assign sched_if.rd_valid   = rd_valid_q;
  assign sched_if.rd_idx     = rd_idx_q;
  assign sched_if.busy       = busy_q;
  assign sched_if.frame_done = frame_done_q;

endmodule

// File: tb/tb_btop_sched.sv
// Directed bench for btop_sched: cycle-by-cycle expected outputs per frame scenario.
module tb_btop_sched;
  import btop_sched_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  btop_sched_if bus ();

  btop_sched dut (
    .clk      (clk),
    .rst      (rst),
    .sched_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_cyc(input string tag, input int c,
                         input int wrdy, input int wen, input int cnta,
                         input int ren, input int cntb, input int rv,
                         input int ridx, input int fd, input int bsy);
    #1;
    chk($sformatf("%s_c%0d_wr_ready", tag, c), bus.wr_ready, wrdy);
    chk($sformatf("%s_c%0d_w_en", tag, c), bus.w_en, wen);
    chk($sformatf("%s_c%0d_cnta", tag, c), bus.cnta, cnta);
    chk($sformatf("%s_c%0d_r_en", tag, c), bus.r_en, ren);
    chk($sformatf("%s_c%0d_cntb", tag, c), bus.cntb, cntb);
    chk($sformatf("%s_c%0d_rd_valid", tag, c), bus.rd_valid, rv);
    if (rv == 1) chk($sformatf("%s_c%0d_rd_idx", tag, c), bus.rd_idx, ridx);
    chk($sformatf("%s_c%0d_frame_done", tag, c), bus.frame_done, fd);
    chk($sformatf("%s_c%0d_busy", tag, c), bus.busy, bsy);
  endtask

  // Both writes done, reads of slots 1..3 then DONE and IDLE; start may be raised in DONE.
  task automatic tail(input string tag, input int c, input bit restart);
    chk_cyc(tag, c,     0, 0, 2, 1, 1, 1, 0, 0, 1);
    tick();
    chk_cyc(tag, c + 1, 0, 0, 2, 1, 2, 1, 1, 0, 1);
    tick();
    chk_cyc(tag, c + 2, 0, 0, 2, 1, 3, 1, 2, 0, 1);
    tick();
    if (restart) bus.start = 1'b1;
    chk_cyc(tag, c + 3, 0, 0, 2, 0, 4, 1, 3, 1, 1);
    tick();
    chk_cyc(tag, c + 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic basic_frame(input string tag, input bit restart);
    bus.start    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.rd_req   = 1'b1;
    chk_cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.start = 1'b0;
    chk_cyc(tag, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_cyc(tag, 2, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    tick();
    tail(tag, 3, restart);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.wr_valid = 1'b1;
    bus.rd_req   = 1'b0;

    // Reset, with a write offered while idle
    tick();
    tick();
    chk_cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_rd_idx", bus.rd_idx, 0);
    rst = 1'b1;
    tick();
    chk_cyc("idle_wr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Minimum frame with write overflow attempt
    tick();
    basic_frame("basic", 1'b0);

    // Reads requested from start, first write at cycle 5
    tick();
    bus.start    = 1'b1;
    bus.wr_valid = 1'b0;
    bus.rd_req   = 1'b1;
    chk_cyc("stall", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk_cyc("stall", c, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    bus.wr_valid = 1'b1;
    chk_cyc("stall", 5, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_cyc("stall", 6, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    tick();
    tail("stall", 7, 1'b0);

    // Only write beat 0: slot 0 readable, slot 1 stalls until beat 1 lands
    tick();
    bus.start    = 1'b1;
    bus.wr_valid = 1'b1;
    chk_cyc("map", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.start = 1'b0;
    chk_cyc("map", 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    bus.wr_valid = 1'b0;
    chk_cyc("map", 2, 1, 0, 1, 1, 0, 0, 0, 0, 1);
    tick();
    chk_cyc("map", 3, 1, 0, 1, 0, 1, 1, 0, 0, 1);
    tick();
    bus.wr_valid = 1'b1;
    chk_cyc("map", 4, 1, 1, 1, 0, 1, 0, 0, 0, 1);
    tick();
    chk_cyc("map", 5, 0, 0, 2, 1, 1, 0, 0, 0, 1);
    tick();
    chk_cyc("map", 6, 0, 0, 2, 1, 2, 1, 1, 0, 1);
    tick();
    chk_cyc("map", 7, 0, 0, 2, 1, 3, 1, 2, 0, 1);
    tick();
    chk_cyc("map", 8, 0, 0, 2, 0, 4, 1, 3, 1, 1);
    tick();
    chk_cyc("map", 9, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset during the cycle of the first read issue
    tick();
    bus.start = 1'b1;
    chk_cyc("mrst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.start = 1'b0;
    chk_cyc("mrst", 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_cyc("mrst", 2, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    rst = 1'b0;
    tick();
    chk_cyc("mrst", 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    basic_frame("after_rst", 1'b0);

    // start held through DONE is ignored; IDLE start runs a frame with a clean scoreboard
    tick();
    basic_frame("b2b_a", 1'b1);
    tick();
    bus.start    = 1'b0;
    bus.wr_valid = 1'b0;
    chk_cyc("b2b_b", 8, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_cyc("b2b_b", 9, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    bus.wr_valid = 1'b1;
    chk_cyc("b2b_b", 10, 1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk_cyc("b2b_b", 11, 1, 1, 1, 1, 0, 0, 0, 0, 1);
    tick();
    tail("b2b_b", 12, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btop_sched.md
# btop_sched

Sequencer for the partial-sum b_top storage RAM in the SCAN polar decoder: admits 2·P·Q-bit write beats from the partial-sum producer, issues P·Q-bit read beats to the LLR update stage, and drives the RAM's write/read counters and enables. A per-slot written-bit scoreboard lets reads of a slot start as soon as the write beat feeding it has landed, so writes and reads of one frame overlap.

## Interface
- N, 1024: code length
- P, 128: processing elements per beat
- Q, 6: bits per stored value
- WBEATS, N/(4·P) (=2): write beats per frame; each beat fills slot k in the low half and slot k+WBEATS in the high half
- RBEATS, N/(2·P) (=4): read beats per frame

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (0 = reset)
- start  in  1  begin a frame; honoured only in IDLE
- wr_valid  in  1  producer offers a write beat
- wr_ready  out  1  controller accepts the beat this cycle
- rd_req  in  1  consumer requests the next read beat (level)
- cnta  out  4  RAM write slot index
- w_en  out  1  RAM write enable
- cntb  out  4  RAM read slot index
- r_en  out  1  RAM read enable
- rd_valid  out  1  RAM data output is valid this cycle
- rd_idx  out  4  slot index of the data qualified by rd_valid
- busy  out  1  high in ACTIVE and DONE
- frame_done  out  1  one-cycle pulse on the last read beat

## Operation
- **States:** IDLE, ACTIVE, DONE.
  - IDLE → ACTIVE when start=1. On entry, wcnt, rcnt and the written[WBEATS-1:0] scoreboard all clear.
  - ACTIVE → DONE in the cycle the last read is issued (r_en=1 with rcnt=RBEATS-1).
  - DONE → IDLE after one cycle.
  - start in ACTIVE or DONE is ignored.
- **Write handshake:**
  - wr_ready = (state==ACTIVE) && (wcnt<WBEATS).
  - A beat transfers when wr_valid && wr_ready. In that cycle: w_en=1, cnta=wcnt; on the next edge, written[wcnt] is set and wcnt increments.
  - When w_en=0, cnta holds wcnt (don't-care to the RAM).
- **Read issue:**
  - r_en = (state==ACTIVE) && rd_req && (rcnt<RBEATS) && written[rcnt mod WBEATS].
  - cntb = rcnt; rcnt increments on each issue.
  - written[] is sampled as a registered value. A read therefore never issues in the same cycle as the write that fills its slot, because the RAM would return the old data.
- **Read return:**
  - rd_valid = r_en delayed one cycle; rd_idx = cntb delayed one cycle.
  - frame_done = rd_valid && rd_idx==RBEATS-1, which coincides with the DONE state.
  - When r_en=0 the RAM output is zero, and the consumer must qualify data with rd_valid.
- **Counters:** wcnt is 4 bits and saturates at WBEATS; rcnt is 4 bits and saturates at RBEATS. Neither wraps within a frame.
- **Simultaneous events:**
  - A write of slot k and a read of an already-written slot j may occur in the same cycle.
  - wr_valid in IDLE or DONE gets no response (wr_ready=0).
  - rd_req with the needed slot unwritten stalls with no error.

## Timing
- **Reset:** when rst=0 at a clock edge, the state goes to IDLE, all counters and the scoreboard clear, and rd_valid, rd_idx and frame_done become 0. wr_ready, w_en, r_en, cnta, cntb and busy are 0 while in IDLE.
- **Reset mid-frame:** same as above. An issued-but-unreturned read produces no rd_valid.
- **Output paths:** w_en, r_en, wr_ready, cnta and cntb are combinational from registered state and inputs (same-cycle handshake). rd_valid, rd_idx and frame_done are registered.
- **Read latency:** rd_req accepted → rd_valid is 1 cycle.
- **Minimum frame:** start at cycle 0; writes at cycles 1–2; reads at cycles 2–5 (slot 0 becomes readable at cycle 2); last rd_valid and frame_done at cycle 6; back to IDLE at cycle 7.

## Structure
- **Shared decoder package:**
  - state enum (IDLE/ACTIVE/DONE)
  - WBEATS/RBEATS derivation functions
  - 4-bit slot-index typedef, shared with the RAM's cnta/cntb
- **Sub-module:** btop_scoreboard, holding the written[] bits with clear/set/query by rcnt mod WBEATS.
- **Single process FSM:** FSM and counters in one clocked process.

## Test plan
- **Basic frame:** rst=0 for 2 cycles, then start; wr_valid=1 and rd_req=1 held continuously → w_en at cycles 1–2 with cnta 0,1; r_en at cycles 2–5 with cntb 0,1,2,3; rd_idx 0..3 at cycles 3–6; frame_done only at cycle 6.
- **Read-before-write stall:** rd_req=1 from start, first wr_valid at cycle 5 → r_en=0 through cycle 5, first r_en at cycle 6 with cntb=0; slot 1 read waits until the cycle after the second write.
- **Slot mapping:** write beat 0 only → reads of cntb 0 and 2 issue, cntb 1 stalls until beat 1 is written.
- **Overflow / idle writes:** wr_valid held after 2 writes → wr_ready=0, no third w_en; wr_valid in IDLE → wr_ready=0.
- **Reset mid-frame:** rst=0 one cycle after an r_en → no rd_valid, busy=0; a new start gives a clean frame identical to the basic-frame scenario.
- **Back-to-back frames:** start asserted in DONE is ignored; start in the following IDLE cycle runs a second frame with the scoreboard cleared, so no read issues before the new writes.
